// File: rtl/lc3_bus_pkg.sv
// lc3_bus_pkg: shared constants and state encoding for the LC-3 bus arbiter.
// Revision: 1.0
`default_nettype none

package lc3_bus_pkg;

  localparam int GATE_PC     = 0;
  localparam int GATE_MDR    = 1;
  localparam int GATE_ALU    = 2;
  localparam int GATE_MARMUX = 3;

  localparam int LC3_N_REQ   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/lc3_rr_pick.sv
// lc3_rr_pick: combinational round-robin picker, first set request at or above pointer (mod N_REQ).
// Revision: 1.0
`default_nettype none

module lc3_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    pointer,
  output logic             found,
  output logic [IW-1:0]    idx
);

  logic [N_REQ:0] none_below;
  logic [IW-1:0]  acc [N_REQ+1];

  assign none_below[0] = 1'b1;
  assign acc[0]        = '0;

  // Candidate k is the requester k steps above the pointer; the lowest k that requests wins.
  for (genvar k = 0; k < N_REQ; k++) begin : g_cand
    logic          wrap;
    logic [IW-1:0] cand;
    logic          hit;

    assign wrap = ({1'b0, pointer} >= (IW+1)'(N_REQ - k));
    assign cand = pointer + IW'(k) - (wrap ? IW'(N_REQ) : IW'(0));
    assign hit  = req[cand] & none_below[k];

    assign none_below[k+1] = none_below[k] & ~req[cand];
    assign acc[k+1]        = acc[k] | ({IW{hit}} & cand);
  end

  assign found = ~none_below[N_REQ];
  assign idx   = acc[N_REQ];

endmodule

`default_nettype wire

// File: rtl/lc3_bus_arbiter.sv
// lc3_bus_arbiter: round-robin one-hot SEL generator for the LC-3 shared bus with bounded hold and turnaround gap.
// Revision: 1.0
`default_nettype none

module lc3_bus_arbiter
  import lc3_bus_pkg::*;
#(
  parameter int N_REQ      = LC3_N_REQ,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                                     CLK,
  input  logic                                     RST_N,
  input  logic [N_REQ-1:0]                         REQ,
  output logic [N_REQ-1:0]                         GNT,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] OWNER,
  output logic                                     BUSY
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    turn_cnt;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          contender;
  logic          release_bus;
  logic [IW-1:0] next_ptr;

  lc3_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req     (REQ),
    .pointer (rr_ptr),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // In GRANT, GNT is onehot(OWNER), so masking with ~GNT isolates the other requesters.
  assign contender   = |(REQ & ~GNT);
  assign release_bus = ~REQ[OWNER] | ((hold_cnt >= HW'(MAX_HOLD)) & contender);
  assign next_ptr    = (OWNER == IW'(N_REQ - 1)) ? '0 : OWNER + IW'(1);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      GNT      <= '0;
      OWNER    <= '0;
      BUSY     <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            GNT      <= N_REQ'(1) << pick_idx;
            OWNER    <= pick_idx;
            BUSY     <= 1'b1;
            hold_cnt <= HW'(1);
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (release_bus) begin
            GNT    <= '0;
            BUSY   <= 1'b0;
            rr_ptr <= next_ptr;
            if (TURNAROUND > 0) begin
              turn_cnt <= 2'd1;
              state    <= TURN;
            end else begin
              state <= IDLE;
            end
          end else if (hold_cnt < HW'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        TURN: begin
          GNT  <= '0;
          BUSY <= 1'b0;
          if (turn_cnt == 2'(TURNAROUND)) begin
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lc3_bus_arbiter.sv
// tb_lc3_bus_arbiter: directed and random stimulus checked against a cycle-level ownership model.
// Revision: 1.0
`default_nettype none

module tb_lc3_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;
  localparam int TA = 1;

  logic         CLK;
  logic         RST_N;
  logic [N-1:0] REQ;
  logic [N-1:0] GNT;
  logic [1:0]   OWNER;
  logic         BUSY;

  int errors;
  int checks;

  // Reference model: who owns the bus, how long it has held it, gap cycles left.
  int m_owner;
  int m_last;
  int m_held;
  int m_gap;
  int m_ptr;

  lc3_bus_arbiter #(
    .N_REQ      (N),
    .MAX_HOLD   (MH),
    .TURNAROUND (TA)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ   (REQ),
    .GNT   (GNT),
    .OWNER (OWNER),
    .BUSY  (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic rn);
    int rv;
    rv = int'(r);
    if (!rn) begin
      m_owner = -1; m_last = 0; m_held = 0; m_gap = 0; m_ptr = 0;
    end else if (m_owner >= 0) begin
      if ((((rv >> m_owner) & 1) == 0) ||
          (m_held >= MH && (rv & ~(1 << m_owner)) != 0)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = TA;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int j = 0; j < N; j++) begin
        int c;
        c = (m_ptr + j) % N;
        if (m_owner < 0 && ((rv >> c) & 1) == 1) begin
          m_owner = c;
          m_last  = c;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rn);
    logic [N-1:0] exp_gnt;
    REQ   = r;
    RST_N = rn;
    @(posedge CLK);
    model_edge(r, rn);
    #1;
    exp_gnt = (m_owner < 0) ? '0 : N'(1 << m_owner);
    check("gnt",    32'(GNT),   32'(exp_gnt));
    check("owner",  32'(OWNER), 32'(m_last));
    check("busy",   32'(BUSY),  32'(m_owner >= 0));
    check("onehot", 32'($countones(GNT) <= 1), 32'd1);
    check("gnt_req", 32'(GNT & ~r), 32'd0);
  endtask

  initial begin
    logic [N-1:0] r;
    errors = 0;
    checks = 0;
    m_owner = -1; m_last = 0; m_held = 0; m_gap = 0; m_ptr = 0;
    REQ   = '0;
    RST_N = 1'b0;

    // Reset with all requesting, then first grant goes to PC.
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    check("first_gnt", 32'(GNT), 32'h1);

    // Single requester (ALU) for four edges, then dropped.
    step(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b1);
    check("alu_owner", 32'(OWNER), 32'd2);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);

    // Full contention: round-robin rotation with hold limit and gaps.
    step(4'b0000, 1'b0);
    for (int i = 0; i < 26; i++) step(4'b1111, 1'b1);

    // No contention: MDR keeps the bus indefinitely.
    step(4'b0000, 1'b0);
    for (int i = 0; i < 12; i++) step(4'b0010, 1'b1);
    check("mdr_kept", 32'(GNT), 32'h2);

    // Reset mid-grant, then pointer restarts at PC.
    step(4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b1);
    step(4'b1000, 1'b0);
    check("mid_rst", 32'(GNT), 32'h0);
    for (int i = 0; i < 2; i++) step(4'b1001, 1'b1);
    check("after_rst", 32'(GNT), 32'h1);

    // Owner drops as MARMUX rises with MDR waiting: MDR wins after the gap.
    step(4'b0000, 1'b0);
    for (int i = 0; i < 2; i++) step(4'b0011, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1010, 1'b1);
    check("simul_owner", 32'(OWNER), 32'd1);
    check("simul_gnt",   32'(GNT),   32'h2);

    // Random sticky requests with occasional reset.
    r = '0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      step(r, ($urandom_range(0, 99) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lc3_bus_arbiter.md
Name: lc3_bus_arbiter

Overview:
- Sequences the LC-3 shared 16-bit bus by generating the one-hot SEL enables for the bus's 16-bit tristate drivers (PC, MDR, ALU, MARMUX).
- Round-robin arbitration with a request/grant handshake, a bounded hold time and a forced all-off turnaround gap between owners, so two drivers never drive the bus simultaneously.
- Sits between the control unit's gate requests and the tristate driver instances on the bus.

Parameters:
- N_REQ, 4, number of bus requesters/drivers (index 0=PC, 1=MDR, 2=ALU, 3=MARMUX).
- MAX_HOLD, 4, max consecutive grant cycles while another requester waits (>=1).
- TURNAROUND, 1, all-gates-off cycles between two owners (0..3).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  reset; one clock; reset is synchronous and active-low.
- REQ  input  N_REQ  per-driver bus request, level; held high for as long as the bus is wanted.
- GNT  output  N_REQ  registered one-hot grant; bit i drives SEL of tristate driver i.
- OWNER  output  clog2(N_REQ)  index of current/last owner.
- BUSY  output  1  high while any GNT bit is high.

Behaviour:
- Reset (RST_N=0 at a rising edge): GNT=0, OWNER=0, BUSY=0, state=IDLE, rr pointer=0, hold_cnt=0, turn_cnt=0. Applies mid-grant; GNT is 0 after that edge. REQ is ignored during reset.
- Invariant: popcount(GNT)<=1 in every cycle.
- Invariant: GNT[i]=1 only if REQ[i] was 1 at the preceding edge.
- States: IDLE, GRANT, TURN. All outputs are registered.
- IDLE:
  - If REQ!=0, pick the first i with REQ[i]=1, searching from the pointer upward mod N_REQ.
  - At that edge: GNT=onehot(i), OWNER=i, hold_cnt=1, go to GRANT. Latency is one edge from REQ to GNT.
  - If REQ==0, stay in IDLE.
- GRANT, evaluated each edge with owner o:
  - Release if REQ[o]=0.
  - Also release if hold_cnt>=MAX_HOLD and (REQ & ~onehot(o))!=0. This is preemption; the owner is not notified and must keep REQ high to be re-served later.
  - Otherwise keep GNT and do hold_cnt++, saturating at MAX_HOLD. With no contender the owner keeps the bus indefinitely.
  - On release: GNT=0 and pointer=(o+1) mod N_REQ. Go to TURN with turn_cnt=1 if TURNAROUND>0, else to IDLE.
- TURN:
  - GNT=0.
  - When turn_cnt==TURNAROUND, go to IDLE; otherwise turn_cnt++.
  - Arbitration in IDLE follows on the next edge, so the bus gap is TURNAROUND+1 cycles when a new requester is already waiting.
- Simultaneous events:
  - Owner drops REQ on the same edge another rises: normal release; the new request is arbitrated after TURN.
  - An owner that re-asserts REQ during TURN is ordered by the pointer, giving it lowest priority.
- Widths: OWNER is $clog2(N_REQ) bits. hold_cnt is $clog2(MAX_HOLD+1) bits. Pointer wrap is mod N_REQ, N_REQ not necessarily a power of two.

Decomposition:
- Shared package lc3_bus_pkg holds:
  - driver index constants GATE_PC=0, GATE_MDR=1, GATE_ALU=2, GATE_MARMUX=3;
  - default N_REQ;
  - state encoding IDLE/GRANT/TURN.
- One combinational sub-module, lc3_rr_pick (inputs REQ, pointer; outputs found, idx), is the round-robin priority picker.
- Counters and the FSM live in the top module.

Test Plan (N_REQ=4, MAX_HOLD=4, TURNAROUND=1):
- Reset: RST_N=0 for 2 edges with REQ=4'b1111 -> GNT=0000, BUSY=0, OWNER=0 throughout. First edge after release -> GNT=0001.
- Single requester: REQ=0100 from edge 1, dropped before edge 5 -> GNT=0100/OWNER=2 after edges 1-4, GNT=0000 after edge 5, 1 TURN cycle, then IDLE.
- Full contention: REQ=1111 held -> GNT sequence 0001 x4, 0000 x2, 0010 x4, 0000 x2, 0100 x4, 0000 x2, 1000 x4, 0000 x2, 0001 again. popcount<=1 is checked every cycle.
- No contention: REQ=0010 held 12 cycles -> GNT=0010 continuously, hold_cnt saturates at 4, no preemption.
- Reset mid-grant: GNT=1000 active, RST_N=0 for one edge -> GNT=0000 after it. Then REQ=1001 -> GNT=0001 (pointer reset to 0).
- Simultaneous: owner 0 drops REQ on the same edge REQ[3] rises, REQ[1] already high -> GNT=0000 for the gap, then GNT=0010, OWNER=1.
